// File: rtl/weighted_round_robin_if.sv
// Arbiter bundle: queue status, weights and enable in; served-queue selector and pop strobe out.
interface weighted_round_robin_if #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int SEL_BITS       = 2,
  parameter int WEIGHT_BITS    = 3
);
  logic                                  enb;
  logic [QUEUE_QUANTITY-1:0]             buf_empty;
  logic                                  dest_full;
  logic [QUEUE_QUANTITY*WEIGHT_BITS-1:0] weights;
  logic [SEL_BITS-1:0]                   selector;
  logic                                  out_enb;

  modport master (
    output enb, buf_empty, dest_full, weights,
    input  selector, out_enb
  );

  modport slave (
    input  enb, buf_empty, dest_full, weights,
    output selector, out_enb
  );
endinterface

// File: rtl/weighted_round_robin.sv
// Weighted round-robin arbiter over QUEUE_QUANTITY FWFT queues toward one consumer.
// Define WRR_PRIO0_EN to give queue 0 strict, preempting priority over the weighted rotation.
module weighted_round_robin #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int SEL_BITS       = 2,
  parameter int WEIGHT_BITS    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  weighted_round_robin_if.slave  bus
);

  logic [SEL_BITS-1:0]       ptr_reg, ptr_next;
  logic [WEIGHT_BITS-1:0]    cnt_reg, cnt_next;
  logic [WEIGHT_BITS-1:0]    weight_arr [QUEUE_QUANTITY];
  logic [QUEUE_QUANTITY-1:0] elig;
  logic [QUEUE_QUANTITY-1:0] search_mask;
  logic [SEL_BITS-1:0]       next_ptr;
  logic [WEIGHT_BITS-1:0]    cur_weight;
  logic [WEIGHT_BITS:0]      cnt_inc;
  logic                      cur_elig;
  logic                      grant;
  logic                      preempt;
  logic                      burst_done;

  genvar gi;
  generate
    for (gi = 0; gi < QUEUE_QUANTITY; gi++) begin : g_queue
      assign weight_arr[gi] = bus.weights[gi*WEIGHT_BITS +: WEIGHT_BITS];
      assign elig[gi]       = ~bus.buf_empty[gi] & (weight_arr[gi] != '0);
    end
  endgenerate

  // Queues that the rotation may move to; queue 0 leaves the rotation when it preempts.
  always_comb begin
    search_mask = elig;
`ifdef WRR_PRIO0_EN
    search_mask[0] = 1'b0;
`endif
  end

  // Successor search starts at ptr+1 and visits ptr itself last.
  always_comb begin
    logic [SEL_BITS-1:0] idx;
    logic                found;
    next_ptr = ptr_reg;
    found    = 1'b0;
    idx      = '0;
    for (int k = 1; k <= QUEUE_QUANTITY; k++) begin
      idx = SEL_BITS'((int'(ptr_reg) + k) % QUEUE_QUANTITY);
      if (!found && search_mask[idx]) begin
        next_ptr = idx;
        found    = 1'b1;
      end
    end
  end

  assign cur_elig   = elig[ptr_reg];
  assign cur_weight = weight_arr[ptr_reg];
  // One bit wider than cnt so the last count of a full-weight burst cannot wrap.
  assign cnt_inc    = {1'b0, cnt_reg} + (WEIGHT_BITS+1)'(1);
  assign burst_done = (cnt_inc >= {1'b0, cur_weight});

`ifdef WRR_PRIO0_EN
  assign preempt = bus.enb & ~rst & ~bus.dest_full & elig[0];
`else
  assign preempt = 1'b0;
`endif

  assign grant = bus.enb & ~rst & ~bus.dest_full & cur_elig & ~preempt;

  // Output process: pop strobe is zero-latency from the current inputs.
  always_comb begin
    bus.out_enb = grant | preempt;
`ifdef WRR_PRIO0_EN
    bus.selector = preempt ? '0 : ptr_reg;
`else
    bus.selector = ptr_reg;
`endif
  end

  // Next-state process, rules checked in priority order.
  always_comb begin
    ptr_next = ptr_reg;
    cnt_next = cnt_reg;
    if (!bus.enb || preempt) begin
      ptr_next = ptr_reg;
      cnt_next = cnt_reg;
    end else if (grant) begin
      if (burst_done) begin
        ptr_next = next_ptr;
        cnt_next = '0;
      end else begin
        cnt_next = cnt_inc[WEIGHT_BITS-1:0];
      end
    end else if (bus.dest_full && cur_elig) begin
      // Stalled by the consumer: keep the burst position for when it drains.
      ptr_next = ptr_reg;
      cnt_next = cnt_reg;
    end else begin
      ptr_next = next_ptr;
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= '0;
      cnt_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
      cnt_reg <= cnt_next;
    end
  end

endmodule
